// File: rtl/decode_stage_pipe.sv
// MIPS-subset decode stage with register file, early branch
// resolution, hazard detection and the ID/EX pipeline register.
module decode_stage_pipe #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int RA_W     = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid_i,
  input  logic [31:0]     if_instr_i,
  input  logic [XLEN-1:0] if_pc4_i,
  input  logic            wb_we_i,
  input  logic [RA_W-1:0] wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            mem_regwr_i,
  input  logic            mem_memrd_i,
  input  logic [RA_W-1:0] mem_rd_i,
  input  logic [XLEN-1:0] mem_alu_i,
  input  logic            ex_stall_i,
  output logic            stall_o,
  output logic            pc_src_o,
  output logic [XLEN-1:0] pc_branch_o,
  output logic            flush_if_o,
  output logic            ex_valid_o,
  output logic [XLEN-1:0] ex_rs_data_o,
  output logic [XLEN-1:0] ex_rt_data_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [RA_W-1:0] ex_rs_o,
  output logic [RA_W-1:0] ex_rt_o,
  output logic [RA_W-1:0] ex_rd_o,
  output logic [3:0]      ex_alu_ctrl_o,
  output logic            ex_regwr_o,
  output logic            ex_memrd_o,
  output logic            ex_memwr_o,
  output logic            ex_alusrc_o
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
    logic [RA_W-1:0] rd;
    logic [3:0]      alu;
    logic            regwr;
    logic            memrd;
    logic            memwr;
    logic            alusrc;
  } idex_t;

  // instruction fields
  logic [5:0]      op;
  logic [5:0]      fn;
  logic [15:0]     imm16;
  logic [RA_W-1:0] rs;
  logic [RA_W-1:0] rt;
  logic [RA_W-1:0] rd;
  logic            unused_shamt;

  assign op    = if_instr_i[31:26];
  assign fn    = if_instr_i[5:0];
  assign imm16 = if_instr_i[15:0];
  assign rs    = RA_W'(if_instr_i[25:21]);
  assign rt    = RA_W'(if_instr_i[20:16]);
  assign rd    = RA_W'(if_instr_i[15:11]);
  assign unused_shamt = ^if_instr_i[10:6];

  // decoded controls
  logic       dec_valid;
  logic [3:0] dec_alu;
  logic       dec_regwr;
  logic       dec_memrd;
  logic       dec_memwr;
  logic       dec_alusrc;
  logic       dec_zext;
  logic       dec_rtype;
  logic       rt_src;
  logic       is_beq;
  logic       is_bne;
  logic       is_br;

  // opcode/funct decoder; unknown encodings fall to a NOP
  always_comb begin
    dec_valid  = 1'b0;
    dec_alu    = ALU_AND;
    dec_regwr  = 1'b0;
    dec_memrd  = 1'b0;
    dec_memwr  = 1'b0;
    dec_alusrc = 1'b0;
    dec_zext   = 1'b0;
    dec_rtype  = 1'b0;
    rt_src     = 1'b0;
    is_beq     = 1'b0;
    is_bne     = 1'b0;
    unique case (1'b1)
      (op == OP_R) && (fn == FN_ADD): begin
        dec_valid = 1'b1; dec_alu = ALU_ADD;
        dec_regwr = 1'b1; dec_rtype = 1'b1;
        rt_src = 1'b1;
      end
      (op == OP_R) && (fn == FN_SUB): begin
        dec_valid = 1'b1; dec_alu = ALU_SUB;
        dec_regwr = 1'b1; dec_rtype = 1'b1;
        rt_src = 1'b1;
      end
      (op == OP_R) && (fn == FN_AND): begin
        dec_valid = 1'b1; dec_alu = ALU_AND;
        dec_regwr = 1'b1; dec_rtype = 1'b1;
        rt_src = 1'b1;
      end
      (op == OP_R) && (fn == FN_OR): begin
        dec_valid = 1'b1; dec_alu = ALU_OR;
        dec_regwr = 1'b1; dec_rtype = 1'b1;
        rt_src = 1'b1;
      end
      (op == OP_R) && (fn == FN_SLT): begin
        dec_valid = 1'b1; dec_alu = ALU_SLT;
        dec_regwr = 1'b1; dec_rtype = 1'b1;
        rt_src = 1'b1;
      end
      op == OP_LW: begin
        dec_valid = 1'b1; dec_alu = ALU_ADD;
        dec_regwr = 1'b1; dec_memrd = 1'b1;
        dec_alusrc = 1'b1;
      end
      op == OP_SW: begin
        dec_valid = 1'b1; dec_alu = ALU_ADD;
        dec_memwr = 1'b1; dec_alusrc = 1'b1;
        rt_src = 1'b1;
      end
      op == OP_BEQ: begin
        dec_valid = 1'b1; dec_alu = ALU_SUB;
        rt_src = 1'b1; is_beq = 1'b1;
      end
      op == OP_BNE: begin
        dec_valid = 1'b1; dec_alu = ALU_SUB;
        rt_src = 1'b1; is_bne = 1'b1;
      end
      op == OP_ADDI: begin
        dec_valid = 1'b1; dec_alu = ALU_ADD;
        dec_regwr = 1'b1; dec_alusrc = 1'b1;
      end
      op == OP_ANDI: begin
        dec_valid = 1'b1; dec_alu = ALU_AND;
        dec_regwr = 1'b1; dec_alusrc = 1'b1;
        dec_zext = 1'b1;
      end
      op == OP_ORI: begin
        dec_valid = 1'b1; dec_alu = ALU_OR;
        dec_regwr = 1'b1; dec_alusrc = 1'b1;
        dec_zext = 1'b1;
      end
      default: ;
    endcase
  end

  assign is_br = is_beq | is_bne;

  // immediate extension
  logic [XLEN-1:0] imm_sx;
  logic [XLEN-1:0] imm_ext;

  assign imm_sx  = {{(XLEN-16){imm16[15]}}, imm16};
  assign imm_ext = dec_zext ? {{(XLEN-16){1'b0}}, imm16} : imm_sx;

  // register file with write-to-read bypass
  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] rs_rf;
  logic [XLEN-1:0] rt_rf;
  logic            wb_ok;

  assign wb_ok = wb_we_i && (wb_rd_i != '0) &&
                 (int'(wb_rd_i) < NUM_REGS);

  assign rs_rf = (rs == '0 || int'(rs) >= NUM_REGS) ? '0 :
                 (wb_we_i && wb_rd_i == rs) ? wb_data_i :
                 regs_q[rs];
  assign rt_rf = (rt == '0 || int'(rt) >= NUM_REGS) ? '0 :
                 (wb_we_i && wb_rd_i == rt) ? wb_data_i :
                 regs_q[rt];

  // regfile write port; cleared on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wb_ok) begin
      regs_q[wb_rd_i] <= wb_data_i;
    end
  end

  // ID/EX state
  idex_t idex_q;
  idex_t idex_d;

  // hazard detection
  logic lu_hit;
  logic br_ex_hit;
  logic br_mem_hit;
  logic hazard;

  assign lu_hit = if_valid_i && dec_valid &&
                  idex_q.valid && idex_q.memrd &&
                  (idex_q.rt != '0) &&
                  ((idex_q.rt == rs) ||
                   (rt_src && idex_q.rt == rt));

  assign br_ex_hit = idex_q.regwr && (idex_q.rd != '0) &&
                     ((idex_q.rd == rs) || (idex_q.rd == rt));

  assign br_mem_hit = mem_memrd_i && (mem_rd_i != '0) &&
                      ((mem_rd_i == rs) || (mem_rd_i == rt));

  assign hazard = lu_hit ||
                  (if_valid_i && is_br && (br_ex_hit || br_mem_hit));

  // branch compare operands with MEM-stage ALU forwarding
  logic            fwd_ok;
  logic [XLEN-1:0] br_a;
  logic [XLEN-1:0] br_b;
  logic            br_eq;
  logic            taken;

  assign fwd_ok = mem_regwr_i && !mem_memrd_i && (mem_rd_i != '0);
  assign br_a   = (fwd_ok && mem_rd_i == rs) ? mem_alu_i : rs_rf;
  assign br_b   = (fwd_ok && mem_rd_i == rt) ? mem_alu_i : rt_rf;
  assign br_eq  = (br_a == br_b);

  assign stall_o = rst_n && (ex_stall_i || hazard);
  assign taken   = rst_n && if_valid_i && !stall_o &&
                   ((is_beq && br_eq) || (is_bne && !br_eq));

  assign pc_src_o    = taken;
  assign flush_if_o  = taken;
  assign pc_branch_o = rst_n ? (if_pc4_i + (imm_sx << 2)) : '0;

  // ID/EX next state: hold, bubble or load
  always_comb begin
    idex_d = idex_q;
    if (ex_stall_i) begin
      idex_d = idex_q;
    end else if (hazard || !if_valid_i || !dec_valid) begin
      idex_d = '0;
    end else begin
      idex_d.valid   = 1'b1;
      idex_d.rs_data = rs_rf;
      idex_d.rt_data = rt_rf;
      idex_d.imm     = imm_ext;
      idex_d.rs      = rs;
      idex_d.rt      = rt;
      idex_d.rd      = dec_rtype ? rd : rt;
      idex_d.alu     = dec_alu;
      idex_d.regwr   = dec_regwr;
      idex_d.memrd   = dec_memrd;
      idex_d.memwr   = dec_memwr;
      idex_d.alusrc  = dec_alusrc;
    end
  end

  // ID/EX register
  always_ff @(posedge clk) begin
    if (!rst_n) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  assign ex_valid_o    = idex_q.valid;
  assign ex_rs_data_o  = idex_q.rs_data;
  assign ex_rt_data_o  = idex_q.rt_data;
  assign ex_imm_o      = idex_q.imm;
  assign ex_rs_o       = idex_q.rs;
  assign ex_rt_o       = idex_q.rt;
  assign ex_rd_o       = idex_q.rd;
  assign ex_alu_ctrl_o = idex_q.alu;
  assign ex_regwr_o    = idex_q.regwr;
  assign ex_memrd_o    = idex_q.memrd;
  assign ex_memwr_o    = idex_q.memwr;
  assign ex_alusrc_o   = idex_q.alusrc;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Scoreboard bench for decode_stage_pipe: directed vectors,
// expected ID/EX contents queued at issue, checked by a monitor.
module tb_decode_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid_i = 1'b0;
  logic [31:0] if_instr_i = '0;
  logic [31:0] if_pc4_i = '0;
  logic        wb_we_i = 1'b0;
  logic [4:0]  wb_rd_i = '0;
  logic [31:0] wb_data_i = '0;
  logic        mem_regwr_i = 1'b0;
  logic        mem_memrd_i = 1'b0;
  logic [4:0]  mem_rd_i = '0;
  logic [31:0] mem_alu_i = '0;
  logic        ex_stall_i = 1'b0;
  logic        stall_o, pc_src_o, flush_if_o, ex_valid_o;
  logic [31:0] pc_branch_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o;
  logic [4:0]  ex_rs_o, ex_rt_o, ex_rd_o;
  logic [3:0]  ex_alu_ctrl_o;
  logic        ex_regwr_o, ex_memrd_o, ex_memwr_o, ex_alusrc_o;

  decode_stage_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid_i(if_valid_i), .if_instr_i(if_instr_i),
    .if_pc4_i(if_pc4_i),
    .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .mem_regwr_i(mem_regwr_i), .mem_memrd_i(mem_memrd_i),
    .mem_rd_i(mem_rd_i), .mem_alu_i(mem_alu_i),
    .ex_stall_i(ex_stall_i),
    .stall_o(stall_o), .pc_src_o(pc_src_o),
    .pc_branch_o(pc_branch_o), .flush_if_o(flush_if_o),
    .ex_valid_o(ex_valid_o),
    .ex_rs_data_o(ex_rs_data_o), .ex_rt_data_o(ex_rt_data_o),
    .ex_imm_o(ex_imm_o),
    .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o),
    .ex_alu_ctrl_o(ex_alu_ctrl_o),
    .ex_regwr_o(ex_regwr_o), .ex_memrd_o(ex_memrd_o),
    .ex_memwr_o(ex_memwr_o), .ex_alusrc_o(ex_alusrc_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rs_d;
    logic [31:0] rt_d;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic        regwr;
    logic        memrd;
    logic        memwr;
    logic        alusrc;
  } exp_t;

  exp_t q[$];
  exp_t last_e = '0;
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic exp_t mk(
    input logic [31:0] a, b, imm,
    input logic [4:0] rs, rt, rd,
    input logic [3:0] alu,
    input logic rw, mr, mw, as);
    exp_t e;
    e = '{a, b, imm, rs, rt, rd, alu, rw, mr, mw, as};
    return e;
  endfunction

  function automatic logic [31:0] rt_i(
    input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] it_i(
    input logic [5:0] op, input logic [4:0] rs, rt,
    input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act, exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // next drive slot: all inputs back to idle except rst_n
  task automatic cyc();
    @(negedge clk);
    if_valid_i  = 1'b0;
    if_instr_i  = '0;
    wb_we_i     = 1'b0;
    wb_rd_i     = '0;
    wb_data_i   = '0;
    mem_regwr_i = 1'b0;
    mem_memrd_i = 1'b0;
    mem_rd_i    = '0;
    mem_alu_i   = '0;
    ex_stall_i  = 1'b0;
  endtask

  task automatic put(input logic [31:0] ins,
                     input logic [31:0] pc4);
    if_valid_i = 1'b1;
    if_instr_i = ins;
    if_pc4_i   = pc4;
  endtask

  task automatic wbw(input logic [4:0] rd,
                     input logic [31:0] d);
    wb_we_i   = 1'b1;
    wb_rd_i   = rd;
    wb_data_i = d;
  endtask

  // monitor: new ID/EX contents pop the scoreboard,
  // held contents must match the last popped entry
  initial begin
    exp_t act, e;
    logic rs_s, hs;
    forever begin
      @(posedge clk);
      rs_s = rst_n;
      hs   = ex_stall_i;
      #1;
      act = {ex_rs_data_o, ex_rt_data_o, ex_imm_o,
             ex_rs_o, ex_rt_o, ex_rd_o, ex_alu_ctrl_o,
             ex_regwr_o, ex_memrd_o, ex_memwr_o, ex_alusrc_o};
      if (rs_s && hs) begin
        n_chk++;
        if (!ex_valid_o || act !== last_e) begin
          n_fail++;
          $display("FAIL hold: got v=%b %h expected %h",
                   ex_valid_o, act, last_e);
        end
      end else if (rs_s && ex_valid_o) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected: got %h expected none", act);
        end else begin
          e = q.pop_front();
          last_e = e;
          if (act !== e) begin
            n_fail++;
            $display("FAIL idex: got %h expected %h", act, e);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // reset: combinational outputs forced low
    cyc();
    put(it_i(6'h04, 5'd0, 5'd0, 16'h0004), 32'h40);
    #4;
    chk("rst_stall", stall_o, 0);
    chk("rst_pcsrc", pc_src_o, 0);
    chk("rst_pcbr", pc_branch_o, 0);
    chk("rst_flush", flush_if_o, 0);
    cyc();
    #4;
    chk("rst_valid", ex_valid_o, 0);
    chk("rst_rsd", ex_rs_data_o, 0);
    chk("rst_ctl", {ex_alu_ctrl_o, ex_regwr_o, ex_memrd_o,
                    ex_memwr_o, ex_alusrc_o}, 0);

    // 1: add r1,r2,r3 after preloading r2/r3
    cyc(); rst_n = 1'b1; wbw(5'd2, 32'd5);
    cyc(); wbw(5'd3, 32'd7);
    cyc(); put(32'h0043_0820, 32'h4);
    q.push_back(mk(5, 7, 32'h820, 2, 3, 1, 4'b0010, 1, 0, 0, 0));
    #4; chk("add_stall", stall_o, 0);

    // 2: load-use, with a WB commit during the stall
    cyc(); put(it_i(6'h23, 5'd1, 5'd4, 16'h0), 32'h8);
    q.push_back(mk(0, 0, 0, 1, 4, 4, 4'b0010, 1, 1, 0, 1));
    #4; chk("lw_stall", stall_o, 0);
    cyc(); put(rt_i(5'd4, 5'd4, 5'd5, 6'h20), 32'hC);
    wbw(5'd4, 32'h44);
    q.push_back(mk(32'h44, 32'h44, 32'h2820, 4, 4, 5,
                   4'b0010, 1, 0, 0, 0));
    #4; chk("lu_stall", stall_o, 1);
    cyc(); put(rt_i(5'd4, 5'd4, 5'd5, 6'h20), 32'hC);
    #4;
    chk("lu_once", stall_o, 0);
    chk("lu_bubble", ex_valid_o, 0);

    // 3: beq / bne resolution
    cyc(); wbw(5'd1, 32'd3);
    cyc(); wbw(5'd2, 32'd3);
    cyc(); put(it_i(6'h04, 5'd1, 5'd2, 16'hFFFC), 32'h100);
    q.push_back(mk(3, 3, 32'hFFFF_FFFC, 1, 2, 2,
                   4'b0110, 0, 0, 0, 0));
    #4;
    chk("beq_taken", pc_src_o, 1);
    chk("beq_target", pc_branch_o, 32'hF0);
    chk("beq_flush", flush_if_o, 1);
    chk("beq_stall", stall_o, 0);
    cyc(); put(it_i(6'h05, 5'd1, 5'd2, 16'hFFFC), 32'h100);
    q.push_back(mk(3, 3, 32'hFFFF_FFFC, 1, 2, 2,
                   4'b0110, 0, 0, 0, 0));
    #4;
    chk("bne_nt", pc_src_o, 0);
    chk("bne_target", pc_branch_o, 32'hF0);

    // branch after ALU producer, then MEM forwarding
    cyc(); put(it_i(6'h08, 5'd0, 5'd1, 16'd9), 32'h1FC);
    q.push_back(mk(0, 3, 9, 0, 1, 1, 4'b0010, 1, 0, 0, 1));
    #4; chk("addi_stall", stall_o, 0);
    cyc(); put(it_i(6'h05, 5'd1, 5'd2, 16'd3), 32'h200);
    q.push_back(mk(3, 3, 3, 1, 2, 2, 4'b0110, 0, 0, 0, 0));
    #4;
    chk("brex_stall", stall_o, 1);
    chk("brex_pcsrc", pc_src_o, 0);
    cyc(); put(it_i(6'h05, 5'd1, 5'd2, 16'd3), 32'h200);
    mem_regwr_i = 1'b1; mem_rd_i = 5'd1; mem_alu_i = 32'd9;
    #4;
    chk("brfwd_stall", stall_o, 0);
    chk("brfwd_taken", pc_src_o, 1);
    chk("brfwd_target", pc_branch_o, 32'h20C);

    // load followed by dependent branch: two stall cycles
    cyc(); put(it_i(6'h23, 5'd0, 5'd9, 16'h0), 32'h2FC);
    q.push_back(mk(0, 0, 0, 0, 9, 9, 4'b0010, 1, 1, 0, 1));
    #4; chk("lw2_stall", stall_o, 0);
    cyc(); put(it_i(6'h04, 5'd9, 5'd0, 16'd1), 32'h300);
    q.push_back(mk(0, 0, 1, 9, 0, 0, 4'b0110, 0, 0, 0, 0));
    #4; chk("ldbr_stall1", stall_o, 1);
    cyc(); put(it_i(6'h04, 5'd9, 5'd0, 16'd1), 32'h300);
    mem_regwr_i = 1'b1; mem_memrd_i = 1'b1; mem_rd_i = 5'd9;
    #4;
    chk("ldbr_stall2", stall_o, 1);
    chk("ldbr_nt", pc_src_o, 0);
    cyc(); put(it_i(6'h04, 5'd9, 5'd0, 16'd1), 32'h300);
    #4;
    chk("ldbr_go", stall_o, 0);
    chk("ldbr_taken", pc_src_o, 1);
    chk("ldbr_target", pc_branch_o, 32'h304);

    // 4: WB bypass and r0 protection
    cyc(); wbw(5'd6, 32'hDEAD);
    put(rt_i(5'd6, 5'd0, 5'd7, 6'h25), 32'h400);
    q.push_back(mk(32'hDEAD, 0, 32'h3825, 6, 0, 7,
                   4'b0001, 1, 0, 0, 0));
    cyc(); wbw(5'd0, 32'd9);
    put(rt_i(5'd0, 5'd6, 5'd11, 6'h25), 32'h404);
    q.push_back(mk(0, 32'hDEAD, 32'h5825, 0, 6, 11,
                   4'b0001, 1, 0, 0, 0));
    cyc(); put(rt_i(5'd0, 5'd0, 5'd12, 6'h24), 32'h408);
    q.push_back(mk(0, 0, 32'h6024, 0, 0, 12,
                   4'b0000, 1, 0, 0, 0));

    // 5: immediates and remaining opcodes
    cyc(); put(it_i(6'h0D, 5'd0, 5'd8, 16'hFFFF), 32'h500);
    q.push_back(mk(0, 0, 32'h0000_FFFF, 0, 8, 8,
                   4'b0001, 1, 0, 0, 1));
    cyc(); put(it_i(6'h08, 5'd0, 5'd8, 16'hFFFF), 32'h504);
    q.push_back(mk(0, 0, 32'hFFFF_FFFF, 0, 8, 8,
                   4'b0010, 1, 0, 0, 1));
    cyc(); put(it_i(6'h2B, 5'd0, 5'd6, 16'd4), 32'h508);
    q.push_back(mk(0, 32'hDEAD, 4, 0, 6, 6, 4'b0010, 0, 0, 1, 1));
    cyc(); put(it_i(6'h0C, 5'd6, 5'd9, 16'h8001), 32'h50C);
    q.push_back(mk(32'hDEAD, 0, 32'h8001, 6, 9, 9,
                   4'b0000, 1, 0, 0, 1));
    cyc(); put(rt_i(5'd2, 5'd3, 5'd15, 6'h2A), 32'h510);
    q.push_back(mk(3, 7, 32'h782A, 2, 3, 15, 4'b0111, 1, 0, 0, 0));
    cyc(); put(rt_i(5'd3, 5'd2, 5'd16, 6'h22), 32'h514);
    q.push_back(mk(7, 3, 32'hFFFF_8022, 3, 2, 16,
                   4'b0110, 1, 0, 0, 0));
    cyc(); put(32'hFC00_0000, 32'h518);
    cyc(); put(rt_i(5'd1, 5'd2, 5'd3, 6'h21), 32'h51C);
    #4;
    chk("nop_op_valid", ex_valid_o, 0);
    chk("nop_op_ctl", {ex_regwr_o, ex_memrd_o, ex_memwr_o}, 0);
    cyc();
    #4;
    chk("nop_fn_valid", ex_valid_o, 0);

    // 6: downstream hold, then reset
    cyc(); put(rt_i(5'd2, 5'd3, 5'd13, 6'h20), 32'h600);
    q.push_back(mk(3, 7, 32'h6820, 2, 3, 13, 4'b0010, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      cyc(); put(it_i(6'h04, 5'd1, 5'd2, 16'hFFFC), 32'h100);
      ex_stall_i = 1'b1;
      #4;
      chk("hold_stall", stall_o, 1);
      chk("hold_pcsrc", pc_src_o, 0);
    end
    cyc(); put(it_i(6'h04, 5'd1, 5'd2, 16'hFFFC), 32'h100);
    q.push_back(mk(3, 3, 32'hFFFF_FFFC, 1, 2, 2,
                   4'b0110, 0, 0, 0, 0));
    #4; chk("rel_taken", pc_src_o, 1);
    cyc(); rst_n = 1'b0;
    put(it_i(6'h04, 5'd1, 5'd2, 16'hFFFC), 32'h100);
    #4;
    chk("rst2_pcsrc", pc_src_o, 0);
    chk("rst2_stall", stall_o, 0);
    chk("rst2_pcbr", pc_branch_o, 0);
    cyc(); rst_n = 1'b1;
    #4;
    chk("rst2_valid", ex_valid_o, 0);
    chk("rst2_data", ex_rs_data_o | ex_rt_data_o | ex_imm_o, 0);
    chk("rst2_idx", {ex_rs_o, ex_rt_o, ex_rd_o, ex_alu_ctrl_o}, 0);
    put(rt_i(5'd2, 5'd3, 5'd1, 6'h20), 32'h4);
    q.push_back(mk(0, 0, 32'h820, 2, 3, 1, 4'b0010, 1, 0, 0, 0));
    cyc();
    cyc();
    #4;
    chk("sb_drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
